ysyx_25040105_ifu: RTL and testbench
====================================

# ysyx_25040105_ifu

Instruction fetch unit of the single-issue ysyx_25040105 core, directly upstream of the decode stage. It owns the architectural PC and issues one fetch request per instruction to the instruction memory port. It holds the returned word until decode accepts it. Control-flow redirects from the execute stage (JAL/JALR/branch) are taken with precedence, and any fetch already in flight is discarded.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset
- XLEN, 32, datapath width (only 32 supported)
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset is asynchronous and active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  XLEN  fetch address, always equal to pc
- imem_resp_valid  in  1  fetched word valid, one pulse per accepted request
- imem_resp_data  in  32  fetched word
- inst_valid  out  1  inst/pc valid toward decode
- inst_ready  in  1  decode consumes inst this cycle
- inst  out  32  instruction word to decode
- pc  out  XLEN  address of inst / current fetch PC
- redirect_valid  in  1  taken jump/branch from execute
- redirect_pc  in  XLEN  redirect target

## Operation
- FSM states: S_IDLE, S_REQ, S_WAIT, S_OUT, S_DRAIN.
- S_IDLE: entered on reset. Goes to S_REQ on the next clock.
- S_REQ:
  - imem_req_valid=1, addr=pc.
  - On handshake (valid & ready), go to S_WAIT.
  - imem_resp_valid is ignored in this state.
- S_WAIT: on imem_resp_valid, latch imem_resp_data into inst and go to S_OUT.
- S_OUT:
  - inst_valid=1.
  - On inst_ready: pc <= pc+4 (mod 2^32), go to S_REQ.
- S_DRAIN:
  - Waits for the orphaned response.
  - On imem_resp_valid, discard the data and go to S_REQ.
- Redirect takes priority over every other transition in every state except S_IDLE. On redirect, pc <= {redirect_pc[31:2],2'b00}, then:
  - S_REQ without handshake: stay in S_REQ. The address may change while the request is unaccepted; the imem protocol permits this.
  - S_REQ with handshake in the same cycle: go to S_DRAIN (the old-pc request is in flight).
  - S_WAIT without resp: go to S_DRAIN.
  - S_WAIT with resp: drop the resp, go to S_REQ.
  - S_OUT: go to S_REQ, and inst_valid deasserts next cycle. If inst_ready was also high, the word counts as consumed, but the pc+4 increment is suppressed.
  - S_DRAIN: pc updated, stay in S_DRAIN (or go to S_REQ if resp arrives the same cycle).
- A redirect in S_IDLE is ignored.
- inst and pc are stable while inst_valid=1 and inst_ready=0.

## Timing
- Reset values (asserted asynchronously):
  - state=S_IDLE, pc=RESET_PC, inst=32'h0000_0013 (NOP).
  - inst_valid=0, imem_req_valid=0.
- imem_req_valid and inst_valid are decoded from registered state only. They have no combinational path from any input.
- Memory response latency is at least 1 cycle after the request handshake; there is no upper bound.
- Throughput with a 1-cycle memory and ready decode is one instruction per 3 cycles (REQ, WAIT, OUT).
- Redirect-to-new-request latency:
  - 1 cycle from S_WAIT or S_OUT.
  - From S_DRAIN, 1 cycle after the orphaned response arrives.
- At most one outstanding memory request at any time.
- Reset asserted mid-operation returns to S_IDLE immediately. A response arriving after reset deasserts, before a new request, must not occur; the memory is reset by the same rst_n.

## Structure
- Shared package ysyx_25040105_pkg holds:
  - the fetch state enum (S_IDLE..S_DRAIN)
  - RESET_PC default
  - INST_NOP (32'h0000_0013)
  - XLEN
- One natural sub-module, ysyx_25040105_pc_reg. It is the PC register with async active-low reset, and load-redirect / increment-by-4 controls with redirect priority.
- The FSM and the inst latch stay in the top module.

## Test plan
- Reset release, memory ready=1 with 1-cycle latency returning 32'h00100093 -> first request addr 32'h8000_0000 one cycle after S_IDLE; inst=32'h00100093, pc=32'h8000_0000, inst_valid=1 on cycle 3; next addr 32'h8000_0004.
- Decode holds inst_ready=0 for 5 cycles in S_OUT -> inst, pc and inst_valid stay constant, no new imem request, pc advances only after ready.
- Redirect to 32'h8000_0102 during S_WAIT; orphan response arrives 4 cycles later -> orphan word never appears on inst; next request addr 32'h8000_0100.
- Redirect in S_OUT coincident with inst_ready=1, target 32'h8000_0040 -> next request addr 32'h8000_0040, not pc+4; inst_valid low for that cycle.
- Redirect in S_REQ with imem_req_ready=0, target 32'h8000_0200 -> same-cycle addr switches to 32'h8000_0200, no drain; with ready=1 the same cycle -> S_DRAIN entered, old response dropped.
- rst_n pulled low while in S_WAIT -> outputs return to reset values asynchronously; after release fetch restarts at 32'h8000_0000.

Source files
------------

// File: rtl/ysyx_25040105_pkg.sv
// Shared definitions for the ysyx_25040105 instruction fetch unit.
//   fetch_state_e    : fetch FSM state encoding
//   XLEN             : datapath width (only 32 supported)
//   RESET_PC_DEFAULT : default PC loaded on reset
//   INST_NOP         : instruction word presented before the first fetch
package ysyx_25040105_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_DRAIN = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/ysyx_25040105_pc_reg.sv
// Architectural PC register.
//   clk, rst_n   : clock, asynchronous active-low reset (pc <= RESET_PC)
//   load         : load redirect target (word-aligned), has priority over inc
//   load_pc      : redirect target
//   inc          : advance pc by 4 (wraps modulo 2^XLEN)
//   pc           : current PC
module ysyx_25040105_pc_reg
  import ysyx_25040105_pkg::*;
#(
  parameter int              PC_W     = ysyx_25040105_pkg::XLEN,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      // Low two bits are forced to zero: fetches are always word aligned.
      pc_q <= load_pc & ~PC_W'(3);
    end else if (inc) begin
      pc_q <= pc_q + PC_W'(4);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ysyx_25040105_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem request per
// instruction, holds the fetched word until decode accepts it, and takes
// execute-stage redirects with priority, discarding any in-flight fetch.
//   clk, rst_n          : clock, asynchronous active-low reset
//   imem_req_*          : fetch request (valid/ready/addr); addr always == pc
//   imem_resp_*         : fetch response, one valid pulse per accepted request
//   inst_valid/ready    : handshake toward decode for inst/pc
//   inst, pc            : instruction word and its address
//   redirect_valid/pc   : taken control-flow target from execute
module ysyx_25040105_ifu
  import ysyx_25040105_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = ysyx_25040105_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         req_valid_q;
  logic         inst_valid_q;
  logic [31:0]  inst_q;
  logic         redirect_take;
  logic         req_hs;
  logic         pc_inc;
  logic         inst_load;

  // Redirects are meaningless before the first fetch has been issued.
  assign redirect_take = redirect_valid && (state_q != S_IDLE);
  assign req_hs        = req_valid_q && imem_req_ready;
  // A redirect coincident with decode acceptance suppresses the increment;
  // pc_reg also gives load priority, this keeps the intent explicit.
  assign pc_inc        = (state_q == S_OUT) && inst_ready && !redirect_take;
  assign inst_load     = (state_q == S_WAIT) && imem_resp_valid && !redirect_take;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ: begin
        // A request accepted together with a redirect is for the stale pc.
        if (req_hs) state_d = redirect_take ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_take)        state_d = imem_resp_valid ? S_REQ : S_DRAIN;
        else if (imem_resp_valid) state_d = S_OUT;
      end
      S_OUT: begin
        if (redirect_take || inst_ready) state_d = S_REQ;
      end
      S_DRAIN: begin
        if (imem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode so they
  // carry no combinational path from any input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= INST_NOP;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= (state_d == S_REQ);
      inst_valid_q <= (state_d == S_OUT);
      if (inst_load) inst_q <= imem_resp_data;
    end
  end

  ysyx_25040105_pc_reg #(
    .PC_W     (XLEN),
    .RESET_PC (XLEN'(RESET_PC))
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (redirect_take),
    .load_pc (redirect_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;

endmodule

// File: tb/tb_ysyx_25040105_ifu.sv
module tb_ysyx_25040105_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int vectors;
  int miscompares;

  ysyx_25040105_ifu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .pc              (pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    #12;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0000_0013);

    // Release reset; a redirect while in S_IDLE must be ignored.
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h1234_5678;
    step();
    redirect_valid = 1'b0;
    chk("req1_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("req1_addr", imem_req_addr, 32'h8000_0000);
    chk("req1_inst_valid", {31'd0, inst_valid}, 32'd0);
    step();
    // S_WAIT: 1-cycle memory answers now.
    imem_req_ready = 1'b0;
    chk("wait1_req_valid", {31'd0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0010_0093;
    step();
    imem_resp_valid = 1'b0;
    chk("out1_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("out1_inst", inst, 32'h0010_0093);
    chk("out1_pc", pc, 32'h8000_0000);
    chk("out1_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // Decode stalls for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst, 32'h0010_0093);
      chk("stall_pc", pc, 32'h8000_0000);
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("req2_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("req2_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("req2_addr", imem_req_addr, 32'h8000_0004);

    // Redirect in S_REQ without handshake: stay in S_REQ with new address.
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    chk("reqredir_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("reqredir_addr", imem_req_addr, 32'h8000_0200);

    // Redirect coincident with handshake: old request drained.
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0300;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("drain1_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("drain1_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("drain1_pc", pc, 32'h8000_0300);
    step();
    chk("drain1b_req_valid", {31'd0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    chk("postdrain1_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("postdrain1_addr", imem_req_addr, 32'h8000_0300);
    chk("postdrain1_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("postdrain1_inst", inst, 32'h0010_0093);

    // Handshake, then redirect during S_WAIT; orphan comes 4 cycles later.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    chk("drain2_pc", pc, 32'h8000_0100);
    for (int i = 0; i < 3; i++) begin
      chk("drain2_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("drain2_inst_valid", {31'd0, inst_valid}, 32'd0);
      step();
    end
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hBADB_AD00;
    step();
    imem_resp_valid = 1'b0;
    chk("postdrain2_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("postdrain2_addr", imem_req_addr, 32'h8000_0100);
    chk("postdrain2_inst", inst, 32'h0010_0093);
    chk("postdrain2_inst_valid", {31'd0, inst_valid}, 32'd0);

    // Normal fetch at 0x8000_0100.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0020_0113;
    step();
    imem_resp_valid = 1'b0;
    chk("out3_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("out3_inst", inst, 32'h0020_0113);
    chk("out3_pc", pc, 32'h8000_0100);

    // Redirect in S_OUT together with inst_ready: no pc+4.
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0040;
    inst_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    chk("outredir_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("outredir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("outredir_addr", imem_req_addr, 32'h8000_0040);

    // Redirect in S_WAIT with same-cycle response: response dropped.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0080;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h1111_1111;
    step();
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b0;
    chk("waitredir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("waitredir_addr", imem_req_addr, 32'h8000_0080);
    chk("waitredir_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("waitredir_inst", inst, 32'h0020_0113);

    // Asynchronous reset while in S_WAIT.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("arst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_pc", pc, 32'h8000_0000);
    chk("arst_inst", inst, 32'h0000_0013);
    #2;
    rst_n = 1'b1;
    step();
    chk("restart_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("restart_addr", imem_req_addr, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
